// File: rtl/fft_bitrev_reader_if.sv
// Output sample stream of the FFT read side.
// Valid/ready handshake with a frame-end marker.
interface fft_bitrev_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  validOut;
  logic                  lastOut;
  logic                  readyIn;

  modport master (
    output dataOut,
    output validOut,
    output lastOut,
    input  readyIn
  );

  modport slave (
    input  dataOut,
    input  validOut,
    input  lastOut,
    output readyIn
  );
endinterface

// File: rtl/fft_bitrev_reader.sv
// Drains one 2**ADDR_WIDTH frame from the sample RAM in bit-reversed order.
// FFT_RD_NATURAL_SEL_EN adds natOrderIn to pick natural order per frame.
module fft_bitrev_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  startIn,
`ifdef FFT_RD_NATURAL_SEL_EN
  input  logic                  natOrderIn,
`endif
  output logic                  busyOut,
  output logic                  doneOut,
  output logic [ADDR_WIDTH-1:0] rdAddrOut,
  output logic                  rdEnOut,
  input  logic [DATA_WIDTH-1:0] rdDataIn,
  fft_bitrev_reader_if.master   strm
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] C_LAST = '1;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_rdAddr;
  logic                  r_rdEn;
  logic                  r_rdLast;
  logic                  r_dv;
  logic                  r_dvLast;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_qD [3];
  logic [2:0]            r_qL;
  logic [1:0]            r_bufCount;

  logic [DATA_WIDTH-1:0] w_qD [3];
  logic [2:0]            w_qL;
  logic [1:0]            w_bufCount;
  logic [1:0]            w_wIdx;
  logic [2:0]            w_commit;
  logic [2:0]            w_credit;
  logic [ADDR_WIDTH-1:0] w_rev;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_valid;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_issue;

  assign w_valid = (r_bufCount != 2'd0);
  assign w_last  = w_valid && r_qL[0];
  assign w_pop   = w_valid && strm.readyIn;

  // Reads already committed: buffered, on rdDataIn, or just requested.
  assign w_commit = {1'b0, r_bufCount}
                  + {2'b00, r_dv}
                  + {2'b00, r_rdEn};
  assign w_credit = w_commit - {2'b00, w_pop};

  // A third slot is only claimed when the consumer is ready, so a stalled
  // consumer sees at most two reads while a ready one gets no gaps.
  assign w_issue = (r_state == S_READ)
                && ((w_credit < 3'd2)
                 || (strm.readyIn && (w_credit < 3'd3)));

  // Mirror the counter bits to form the bit-reversed address.
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      w_rev[ADDR_WIDTH-1-i] = r_cnt[i];
    end
  end

`ifdef FFT_RD_NATURAL_SEL_EN
  logic r_nat;

  // Order choice is latched with the accepted start.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_nat <= 1'b0;
    end else if ((r_state == S_IDLE) && startIn) begin
      r_nat <= natOrderIn;
    end
  end

  assign w_addr = r_nat ? r_cnt : w_rev;
`else
  assign w_addr = w_rev;
`endif

  // Frame FSM and registered read request.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rdAddr <= '0;
      r_rdEn   <= 1'b0;
      r_rdLast <= 1'b0;
    end else begin
      r_rdEn   <= 1'b0;
      r_rdLast <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (startIn) begin
            r_state  <= S_READ;
            r_rdEn   <= 1'b1;
            r_rdAddr <= '0;
            r_cnt    <= ADDR_WIDTH'(1);
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_rdEn   <= 1'b1;
            r_rdAddr <= w_addr;
            r_rdLast <= (r_cnt == C_LAST);
            r_cnt    <= r_cnt + ADDR_WIDTH'(1);
            if (r_cnt == C_LAST) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && w_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Frame-complete pulse follows the final transfer.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_pop && w_last;
    end
  end

  assign w_bufCount = r_bufCount
                    + {1'b0, r_dv}
                    - {1'b0, w_pop};
  assign w_wIdx = r_bufCount - {1'b0, w_pop};

  // Head-at-slot-0 buffer: pop shifts down, arriving data fills behind.
  always_comb begin
    w_qD = r_qD;
    w_qL = r_qL;
    if (w_pop) begin
      w_qD[0] = r_qD[1];
      w_qD[1] = r_qD[2];
      w_qL[0] = r_qL[1];
      w_qL[1] = r_qL[2];
    end
    if (r_dv) begin
      if (w_wIdx == 2'd0) begin
        w_qD[0] = rdDataIn;
        w_qL[0] = r_dvLast;
      end else if (w_wIdx == 2'd1) begin
        w_qD[1] = rdDataIn;
        w_qL[1] = r_dvLast;
      end else begin
        w_qD[2] = rdDataIn;
        w_qL[2] = r_dvLast;
      end
    end
  end

  // Track RAM read latency and update the output buffer.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_dv       <= 1'b0;
      r_dvLast   <= 1'b0;
      r_bufCount <= 2'd0;
      r_qD       <= '{default: '0};
      r_qL       <= '0;
    end else begin
      r_dv       <= r_rdEn;
      r_dvLast   <= r_rdLast;
      r_bufCount <= w_bufCount;
      r_qD       <= w_qD;
      r_qL       <= w_qL;
    end
  end

  assign busyOut       = (r_state != S_IDLE);
  assign doneOut       = r_done;
  assign rdAddrOut     = r_rdAddr;
  assign rdEnOut       = r_rdEn;
  assign strm.dataOut  = r_qD[0];
  assign strm.validOut = w_valid;
  assign strm.lastOut  = w_last;

endmodule
